// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 CBC front end.
package aes_pkg;

   // One AES block, byte order identical to the datapath.
   typedef logic [127:0] block_t;

   // Chainer control states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WAIT   = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   // Cycles from a datapath input change to a valid datapath output.
   localparam int DATAPATH_LATENCY = 15;

endpackage : aes_pkg

// File: rtl/aes_cbc_chainer.sv
// CBC chaining stage in front of the fixed-latency AES-256 datapath.
// One block in flight at a time: XOR plaintext with the chain value,
// wait PIPE_LATENCY cycles, capture ciphertext as output and new chain.
module aes_cbc_chainer
   import aes_pkg::*;
#(
   parameter int PIPE_LATENCY = DATAPATH_LATENCY   // must be >= 1
) (
   input  logic         sys_clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] iv,
   input  logic [127:0] pt_data,
   input  logic         pt_valid,
   input  logic         pt_last,
   output logic         pt_ready,
   output logic [127:0] core_in,
   input  logic [127:0] core_out,
   output logic [127:0] ct_data,
   output logic         ct_valid,
   output logic         ct_last,
   input  logic         ct_ready,
   output logic         busy
);

   localparam int CNT_W = $clog2(PIPE_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PIPE_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q,   state_d;
   block_t           chain_q,   chain_d;
   block_t           core_in_q, core_in_d;
   block_t           ct_data_q, ct_data_d;
   logic             ct_last_q, ct_last_d;
   logic             last_q,    last_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   // State and datapath registers; reset aborts any block in flight.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         chain_q   <= '0;
         core_in_q <= '0;
         ct_data_q <= '0;
         ct_last_q <= 1'b0;
         last_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         chain_q   <= chain_d;
         core_in_q <= core_in_d;
         ct_data_q <= ct_data_d;
         ct_last_q <= ct_last_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state logic; every register holds unless its state updates it.
   always_comb begin
      state_d   = state_q;
      chain_d   = chain_q;
      core_in_d = core_in_q;
      ct_data_d = ct_data_q;
      ct_last_d = ct_last_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               chain_d = iv;
               state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            if (pt_valid) begin
               core_in_d = pt_data ^ chain_q;
               last_d    = pt_last;
               cnt_d     = CNT_LOAD;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            // Exit at 1 so the counter never wraps through zero.
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               ct_data_d = core_out;
               chain_d   = core_out;
               ct_last_d = last_q;
               state_d   = OUTPUT;
            end
         end
         OUTPUT: begin
            if (ct_ready) begin
               state_d = ct_last_q ? IDLE : ACCEPT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake flags are pure state decodes, so they are mutually exclusive.
   assign pt_ready = (state_q == ACCEPT);
   assign ct_valid = (state_q == OUTPUT);
   assign busy     = (state_q != IDLE);
   assign core_in  = core_in_q;
   assign ct_data  = ct_data_q;
   assign ct_last  = ct_last_q;

endmodule : aes_cbc_chainer

// File: tb/tb_aes_cbc_chainer.sv
// Scoreboard bench for aes_cbc_chainer: a 15-cycle stub datapath instance
// and a 1-cycle stub instance, each with its own expected-response queue.
module tb_aes_cbc_chainer;
   import aes_pkg::*;

   localparam int L0 = 15;

   localparam block_t NIST_IV  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam block_t NIST_PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam block_t NIST_CT1 = 128'hf58c4c04d6e5f1ba779eabfb5f7bfbd6;
   localparam block_t NIST_PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam block_t NIST_CT2 = 128'h9cfc4e967edb808d679f777bc6702c7d;

   typedef struct {
      block_t data;
      logic   last;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst;
   int     cyc = 0;
   int     errors = 0;
   int     checks = 0;

   // DUT 0 (15-cycle datapath)
   logic   start, pt_valid, pt_last, ct_ready;
   block_t iv, pt_data;
   logic   pt_ready, ct_valid, ct_last, busy;
   block_t core_in, core_out, ct_data;

   // DUT 1 (1-cycle datapath)
   logic   start1, pt_valid1, pt_last1, ct_ready1;
   block_t iv1, pt_data1;
   logic   pt_ready1, ct_valid1, ct_last1, busy1;
   block_t core_in1, core_out1, ct_data1;

   exp_t   exp_q[$];
   exp_t   exp_q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_cbc_chainer #(.PIPE_LATENCY(L0)) dut (
      .sys_clk(clk), .rst(rst), .start(start), .iv(iv),
      .pt_data(pt_data), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
      .core_in(core_in), .core_out(core_out),
      .ct_data(ct_data), .ct_valid(ct_valid), .ct_last(ct_last), .ct_ready(ct_ready),
      .busy(busy)
   );

   aes_cbc_chainer #(.PIPE_LATENCY(1)) dut1 (
      .sys_clk(clk), .rst(rst), .start(start1), .iv(iv1),
      .pt_data(pt_data1), .pt_valid(pt_valid1), .pt_last(pt_last1), .pt_ready(pt_ready1),
      .core_in(core_in1), .core_out(core_out1),
      .ct_data(ct_data1), .ct_valid(ct_valid1), .ct_last(ct_last1), .ct_ready(ct_ready1),
      .busy(busy1)
   );

   // Stub cipher: maps the two NIST CBC-AES256 block inputs to their
   // published outputs, identity for everything else.
   function automatic block_t cipher(input block_t x);
      if (x == (NIST_PT1 ^ NIST_IV)) return NIST_CT1;
      if (x == (NIST_PT2 ^ NIST_CT1)) return NIST_CT2;
      return x;
   endfunction

   // 15-cycle stub: core_in register plus 14 delay stages.
   block_t dl [L0-1];
   always @(posedge clk) begin
      dl[0] <= core_in;
      for (int i = 1; i < L0 - 1; i++) dl[i] <= dl[i-1];
   end
   assign core_out  = cipher(dl[L0-2]);
   // 1-cycle stub: the core_in register alone.
   assign core_out1 = cipher(core_in1);

   task automatic check(input string name, input block_t act, input block_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor for DUT 0: scoreboard, latency and busy-drop checks.
   int   hs_edge = 0;
   logic ct_valid_prev = 1'b0;
   logic busy_chk = 1'b0;
   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         ct_valid_prev = 1'b0;
         busy_chk = 1'b0;
      end else begin
         if (pt_valid && pt_ready) hs_edge = cyc + 1;
         if (ct_valid && !ct_valid_prev)
            check("ct_valid_latency", block_t'(cyc - hs_edge), block_t'(L0));
         if (busy_chk) begin
            check("busy_after_last", block_t'(busy), block_t'(0));
            busy_chk = 1'b0;
         end
         if (ct_valid && ct_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ct: got %h expected none", ct_data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("ct_data", ct_data, e.data);
               check("ct_last", block_t'(ct_last), block_t'(e.last));
               $display("ct0 data=%h last=%0d", ct_data, ct_last);
            end
            if (ct_last) busy_chk = 1'b1;
         end
         ct_valid_prev = ct_valid;
      end
   end

   // Monitor for DUT 1.
   always @(negedge clk) begin
      if (rst === 1'b0 && ct_valid1 && ct_ready1) begin
         if (exp_q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ct1: got %h expected none", ct_data1);
         end else begin
            exp_t e;
            e = exp_q1.pop_front();
            check("ct1_data", ct_data1, e.data);
            check("ct1_last", block_t'(ct_last1), block_t'(e.last));
            $display("ct1 data=%h last=%0d", ct_data1, ct_last1);
         end
      end
   end

   // All drive tasks start and end 1 ns after a rising edge.
   task automatic do_start(input block_t v);
      start = 1'b1; iv = v;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_pt(input block_t d, input logic l, input block_t e, input bit push);
      bit ok = 0;
      exp_t x;
      pt_data = d; pt_last = l; pt_valid = 1'b1;
      if (push) begin
         x.data = e; x.last = l;
         exp_q.push_back(x);
      end
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (pt_ready) ok = 1;
         @(posedge clk); #1;
      end
      pt_valid = 1'b0; pt_last = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL pt_timeout: got no pt_ready expected handshake");
      end
      $display("pt0 data=%h last=%0d", d, l);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) ok = 1;
      end
      @(posedge clk); #1;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL idle_timeout: got busy=%0d pending=%0d expected idle", busy, exp_q.size());
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_core_in"},  core_in,  '0);
      check({tag, "_ct_data"},  ct_data,  '0);
      check({tag, "_ct_valid"}, block_t'(ct_valid), '0);
      check({tag, "_ct_last"},  block_t'(ct_last),  '0);
      check({tag, "_pt_ready"}, block_t'(pt_ready), '0);
      check({tag, "_busy"},     block_t'(busy),     '0);
   endtask

   initial begin
      block_t held;
      block_t vec1 [4];
      block_t exp1 [4];
      int     hs1 [4];
      exp_t   x;
      bit     ok;

      vec1 = '{128'h2, 128'h4, 128'h8, 128'h10};
      exp1 = '{128'h3, 128'h7, 128'hF, 128'h1F};

      rst = 1'b1; start = 0; iv = '0; pt_data = '0; pt_valid = 0; pt_last = 0; ct_ready = 1;
      start1 = 0; iv1 = '0; pt_data1 = '0; pt_valid1 = 0; pt_last1 = 0; ct_ready1 = 1;
      #1;
      check_reset_outputs("por");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("post_rst");

      // Identity cipher, iv = 0: CT1 = PT1, CT2 = CT1 ^ 0 = CT1.
      do_start('0);
      @(negedge clk);
      check("pt_ready_after_start", block_t'(pt_ready), 128'h1);
      @(posedge clk); #1;
      send_pt(128'h0123456789abcdef0123456789abcdef, 1'b0, 128'h0123456789abcdef0123456789abcdef, 1);
      check("core_in_blk1", core_in, 128'h0123456789abcdef0123456789abcdef);
      send_pt('0, 1'b1, 128'h0123456789abcdef0123456789abcdef, 1);
      wait_idle();

      // NIST SP800-38A CBC-AES256 vectors.
      do_start(NIST_IV);
      send_pt(NIST_PT1, 1'b0, NIST_CT1, 1);
      check("core_in_nist1", core_in, NIST_PT1 ^ NIST_IV);
      send_pt(NIST_PT2, 1'b1, NIST_CT2, 1);
      wait_idle();
      check("core_in_held_idle", core_in, NIST_PT2 ^ NIST_CT1);

      // Backpressure: hold ct_ready low 40 cycles in OUTPUT.
      ct_ready = 1'b0;
      do_start(128'h1);
      send_pt(128'h10, 1'b0, 128'h11, 1);
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (ct_valid) ok = 1;
      end
      check("bp_reached_output", block_t'(ok), 128'h1);
      held = ct_data;
      check("bp_held_value", held, 128'h11);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("bp_ct_data_stable", ct_data, held);
         check("bp_pt_ready_low", block_t'(pt_ready), 128'h0);
      end
      @(posedge clk); #1;
      ct_ready = 1'b1;
      send_pt(128'h100, 1'b1, 128'h111, 1);
      wait_idle();

      // start pulsed during WAIT with a different iv is ignored.
      do_start(128'hA0);
      send_pt(128'h0A, 1'b0, 128'hAA, 1);
      do_start(128'hFF);
      send_pt(128'h05, 1'b1, 128'hAF, 1);
      wait_idle();

      // Reset 5 cycles into WAIT aborts the block; next message uses new iv only.
      do_start(128'h55);
      send_pt(128'h0F, 1'b0, '0, 0);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      do_start(128'h3000);
      send_pt(128'h4, 1'b1, 128'h3004, 1);
      wait_idle();

      // PIPE_LATENCY = 1 instance, continuous valid/ready.
      start1 = 1'b1; iv1 = 128'h1;
      @(posedge clk); #1;
      start1 = 1'b0;
      pt_valid1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         pt_data1 = vec1[k];
         pt_last1 = (k == 3);
         x.data = exp1[k]; x.last = (k == 3);
         exp_q1.push_back(x);
         ok = 0;
         hs1[k] = 0;
         for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (pt_ready1) begin ok = 1; hs1[k] = cyc + 1; end
            @(posedge clk); #1;
         end
         if (!ok) begin
            checks++; errors++;
            $display("FAIL pt1_timeout: got no pt_ready expected handshake");
         end
         $display("pt1 data=%h last=%0d", vec1[k], (k == 3));
      end
      pt_valid1 = 1'b0; pt_last1 = 1'b0;
      for (int k = 1; k < 4; k++)
         check("l1_block_period", block_t'(hs1[k] - hs1[k-1]), 128'd3);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (!busy1 && exp_q1.size() == 0) ok = 1;
      end
      check("l1_drained", block_t'(ok), 128'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_aes_cbc_chainer
